// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction while it executes and computes the next PC on retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pcplus4_w;
  logic [31:0] branch_off;
  logic [31:0] jump_tgt;
  logic [31:0] next_pc;

  assign pcplus4_w  = pc_q + 32'd4;
  assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_tgt   = {pcplus4_w[31:28], instr_q[25:0], 2'b00};

  // Jump outranks branch when the controller raises both.
  always_comb begin
    if (jump)       next_pc = jump_tgt;
    else if (pcsrc) next_pc = pcplus4_w + branch_off;
    else            next_pc = pcplus4_w;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RST;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Request is a pure decode of the state register, so it drops with reset.
  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign instr_valid = (state_q == ST_HOLD);
  assign pc          = pc_q;
  assign pcplus4     = pcplus4_w;
  assign instr_count = count_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the main controller and datapath in the single-cycle MIPS core. It owns the program counter, fetches each instruction from instruction memory over a req/ack handshake, and holds it stable while the controller decodes `op`/`funct` and the datapath executes. When the datapath retires the instruction, the unit computes the next PC from the controller's `pcsrc`/`jump` decisions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; must be word aligned.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: fetch address (= `pc`).
- `imem_ack` input 1: memory returns data this cycle.
- `imem_rdata` input 32: instruction word, valid when `imem_ack` is high.
- `instr` output 32: held instruction register.
- `op` output 6: `instr[31:26]`, to controller.
- `funct` output 6: `instr[5:0]`, to controller.
- `instr_valid` output 1: `instr` is valid and under execution.
- `retire` input 1: datapath has finished the current instruction.
- `pcsrc` input 1: take branch (from controller), sampled on retire.
- `jump` input 1: take jump (from controller), sampled on retire.
- `pc` output 32: address of the current instruction.
- `pcplus4` output 32: `pc + 4`, combinational.
- `instr_count` output 32: number of retired instructions.

## Operation
- FSM states: RST, FETCH, HOLD.
  - RST to FETCH unconditionally on the next edge.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`, both held stable until ack. On `imem_ack`, `instr` <= `imem_rdata` and the FSM goes to HOLD.
  - HOLD: `instr_valid`=1. On `retire`, `pc` <= next PC, `instr_count` increments, and the FSM goes to FETCH. Without `retire` it stays in HOLD and `instr` is held.
- Next-PC priority, evaluated on the retire cycle:
  - `jump`=1: `{pcplus4[31:28], instr[25:0], 2'b00}`.
  - Otherwise `pcsrc`=1: `pcplus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Otherwise: `pcplus4`.
  - `jump` and `pcsrc` both high: jump wins.
- Arithmetic is 32-bit modulo 2^32; the carry is discarded, so `pc`=32'hFFFF_FFFC gives `pcplus4`=0. `imem_addr[1:0]` is always 2'b00.
- `retire`, `pcsrc` and `jump` are ignored outside HOLD.
- `imem_ack` is ignored outside FETCH. `imem_rdata` is not sampled without ack.
- `instr_count` wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-operation (any state): immediate return to reset values. A pending memory request is abandoned (`imem_req` drops asynchronously). A late `imem_ack` arriving in RST is ignored.

## Timing
- Reset values:
  - State RST.
  - `pc`=`RESET_PC`; `pcplus4`=`RESET_PC+4`.
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
  - `instr`=0, so `op`=0 and `funct`=0.
  - `instr_valid`=0; `instr_count`=0.
- First `imem_req` is in the 2nd rising edge after reset release (RST occupies one cycle).
- Ack in the same cycle as req (zero wait): `instr_valid` is high from the next cycle.
- N wait cycles add N cycles.
- `retire` may be asserted in the first `instr_valid` cycle. Best throughput is one instruction per 2 cycles (FETCH + HOLD).
- After the retire edge, `instr_valid`=0 and `imem_req`=1 with the new `pc` in the same cycle. No bubble beyond the FETCH state.
- All outputs are registered or derived combinationally from registers only. No input-to-output combinational path except none; `imem_req` depends on state only.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0, release reset, memory acks at once with 32'h2008_0005.
  - `imem_req` is high in cycle 2 with `imem_addr`=0.
  - Next cycle: `instr_valid`=1, `op`=6'h08, `pc`=0.
- **Sequential execution:** three instructions, `retire` with `pcsrc`=`jump`=0. Expect `imem_addr` sequence 0, 4, 8 and `instr_count`=3.
- **Branch:** at `pc`=8, `instr`=32'h1000_0003, retire with `pcsrc`=1 → next `imem_addr`=32'h18. Repeat with offset 16'hFFFF → next `imem_addr`=8.
- **Jump and priority:** at `pc`=32'h10, `instr`=32'h0800_0010, retire with `jump`=1 and `pcsrc`=1 → next `imem_addr`=32'h40.
- **Wait states and stall:**
  - Hold `imem_ack` low for 5 cycles: `imem_req` and `imem_addr` stay stable and `instr_valid` stays 0.
  - Then hold `retire` low for 4 cycles in HOLD: `instr`, `pc` and `instr_count` are unchanged.
  - Stray `retire`/`jump` pulses during FETCH have no effect.
- **Reset mid-fetch and wrap:**
  - Assert reset while `imem_req`=1: outputs return to reset values immediately, and an ack arriving in RST is ignored.
  - Start with `RESET_PC`=32'hFFFF_FFFC: after retire, `imem_addr`=0.
